// File: rtl/instruction_fetch_controller_if.sv
// Fetch-side bundle: redirect input, I-cache request/response and FIFO write/flush ports.
// The master modport is the fetch controller; the slave modport is the I-cache/FIFO/branch side.
interface instruction_fetch_controller_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_delay_slot;

    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_ack;
    logic [31:0] icache_data0;
    logic [31:0] icache_data1;

    logic        fifo_full;
    logic        fifo_write_en1;
    logic        fifo_write_en2;
    logic [31:0] fifo_write_data1;
    logic [31:0] fifo_write_data2;
    logic [31:0] fifo_write_address1;
    logic [31:0] fifo_write_address2;
    logic        fifo_flush;
    logic        fifo_flush_with_delay;

    modport master (
        input  redirect_valid, redirect_pc, redirect_delay_slot,
        input  icache_ack, icache_data0, icache_data1, fifo_full,
        output icache_req, icache_addr,
        output fifo_write_en1, fifo_write_en2, fifo_write_data1, fifo_write_data2,
        output fifo_write_address1, fifo_write_address2,
        output fifo_flush, fifo_flush_with_delay
    );

    modport slave (
        output redirect_valid, redirect_pc, redirect_delay_slot,
        output icache_ack, icache_data0, icache_data1, fifo_full,
        input  icache_req, icache_addr,
        input  fifo_write_en1, fifo_write_en2, fifo_write_data1, fifo_write_data2,
        input  fifo_write_address1, fifo_write_address2,
        input  fifo_flush, fifo_flush_with_delay
    );
endinterface

// File: rtl/instruction_fetch_controller.sv
// Fetch sequencer: one outstanding I-cache request at a time, writes one or two
// instructions per response into the dual-issue FIFO, discards responses after a redirect.
module instruction_fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                              clk,
    input  logic                              rst,
    instruction_fetch_controller_if.master    bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic        icache_req_reg;
    logic [31:0] icache_addr_reg;
    logic        write_fire;
    logic        pair_fetch;

    // Only a clean ack in WAIT is kept; a same-cycle redirect wins over the ack.
    assign write_fire = !rst && (state_reg == WAIT) && bus.icache_ack && !bus.redirect_valid;
    assign pair_fetch = !pc_reg[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            pc_reg          <= RESET_PC;
            icache_req_reg  <= 1'b0;
            icache_addr_reg <= RESET_PC;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.redirect_valid) begin
                        pc_reg <= bus.redirect_pc;
                    end else if (!bus.fifo_full) begin
                        icache_req_reg  <= 1'b1;
                        icache_addr_reg <= pc_reg;
                        state_reg       <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.redirect_valid) begin
                        pc_reg <= bus.redirect_pc;
                        if (bus.icache_ack) begin
                            icache_req_reg <= 1'b0;
                            state_reg      <= IDLE;
                        end else begin
                            state_reg <= DROP;
                        end
                    end else if (bus.icache_ack) begin
                        pc_reg         <= pc_reg + (pair_fetch ? 32'd8 : 32'd4);
                        icache_req_reg <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                DROP: begin
                    if (bus.redirect_valid) begin
                        pc_reg <= bus.redirect_pc;
                    end
                    // The request stays up with its original address until the stale ack arrives.
                    if (bus.icache_ack) begin
                        icache_req_reg <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: begin
                    icache_req_reg <= 1'b0;
                    state_reg      <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.fifo_write_en1      = 1'b0;
        bus.fifo_write_en2      = 1'b0;
        bus.fifo_write_data1    = 32'd0;
        bus.fifo_write_data2    = 32'd0;
        bus.fifo_write_address1 = 32'd0;
        bus.fifo_write_address2 = 32'd0;
        if (write_fire) begin
            bus.fifo_write_en1      = 1'b1;
            bus.fifo_write_data1    = bus.icache_data0;
            bus.fifo_write_address1 = pc_reg;
            if (pair_fetch) begin
                bus.fifo_write_en2      = 1'b1;
                bus.fifo_write_data2    = bus.icache_data1;
                bus.fifo_write_address2 = pc_reg + 32'd4;
            end
        end
    end

    assign bus.icache_req            = icache_req_reg;
    assign bus.icache_addr           = icache_addr_reg;
    assign bus.fifo_flush            = !rst && bus.redirect_valid;
    assign bus.fifo_flush_with_delay = !rst && bus.redirect_valid && bus.redirect_delay_slot;
endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Directed bench for instruction_fetch_controller: the bench plays I-cache, FIFO and
// branch unit, and checks every output against hand-computed values.
module tb_instruction_fetch_controller;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    instruction_fetch_controller_if bus();

    instruction_fetch_controller #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h want=%08h", tag, got, exp);
        end else begin
            $display("ok   %s = %08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_on(input logic [31:0] d0, input logic [31:0] d1);
        bus.icache_ack   = 1'b1;
        bus.icache_data0 = d0;
        bus.icache_data1 = d1;
        #1;
    endtask

    task automatic ack_off();
        bus.icache_ack   = 1'b0;
        bus.icache_data0 = 32'd0;
        bus.icache_data1 = 32'd0;
    endtask

    task automatic redir(input logic [31:0] pc, input logic ds);
        bus.redirect_valid      = 1'b1;
        bus.redirect_pc         = pc;
        bus.redirect_delay_slot = ds;
        #1;
    endtask

    task automatic redir_off();
        bus.redirect_valid      = 1'b0;
        bus.redirect_pc         = 32'd0;
        bus.redirect_delay_slot = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        redir_off();
        ack_off();
        bus.fifo_full = 1'b0;
        tick();
        tick();

        // Reset state, flush masked during reset
        chk("rst_req", 32'(bus.icache_req), 32'd0);
        chk("rst_addr", bus.icache_addr, 32'hBFC0_0000);
        redir(32'h1234_5678, 1'b1);
        chk("rst_flush", 32'(bus.fifo_flush), 32'd0);
        chk("rst_flush_dly", 32'(bus.fifo_flush_with_delay), 32'd0);
        redir_off();
        ack_on(32'hAAAA_0000, 32'hAAAA_0001);
        chk("rst_wen1", 32'(bus.fifo_write_en1), 32'd0);
        ack_off();

        // Sequential fetch from reset PC
        rst = 1'b0;
        tick();
        chk("seq0_req", 32'(bus.icache_req), 32'd1);
        chk("seq0_addr", bus.icache_addr, 32'hBFC0_0000);
        ack_on(32'hA000_0000, 32'hA000_0001);
        chk("seq0_wen1", 32'(bus.fifo_write_en1), 32'd1);
        chk("seq0_wen2", 32'(bus.fifo_write_en2), 32'd1);
        chk("seq0_d1", bus.fifo_write_data1, 32'hA000_0000);
        chk("seq0_a1", bus.fifo_write_address1, 32'hBFC0_0000);
        chk("seq0_d2", bus.fifo_write_data2, 32'hA000_0001);
        chk("seq0_a2", bus.fifo_write_address2, 32'hBFC0_0004);
        tick();
        ack_off();
        chk("seq0_idle_req", 32'(bus.icache_req), 32'd0);
        tick();
        chk("seq1_req", 32'(bus.icache_req), 32'd1);
        chk("seq1_addr", bus.icache_addr, 32'hBFC0_0008);
        ack_on(32'hA000_0002, 32'hA000_0003);
        chk("seq1_a1", bus.fifo_write_address1, 32'hBFC0_0008);
        chk("seq1_a2", bus.fifo_write_address2, 32'hBFC0_000C);
        chk("seq1_d2", bus.fifo_write_data2, 32'hA000_0003);
        tick();
        ack_off();
        #1;
        chk("seq1_idle_req", 32'(bus.icache_req), 32'd0);
        chk("seq1_idle_wen1", 32'(bus.fifo_write_en1), 32'd0);

        // Odd start: redirect in IDLE to a pc with bit 2 set
        redir(32'h8000_0004, 1'b0);
        chk("odd_flush", 32'(bus.fifo_flush), 32'd1);
        chk("odd_flush_dly", 32'(bus.fifo_flush_with_delay), 32'd0);
        tick();
        redir_off();
        chk("odd_redir_req", 32'(bus.icache_req), 32'd0);
        tick();
        chk("odd_req", 32'(bus.icache_req), 32'd1);
        chk("odd_addr", bus.icache_addr, 32'h8000_0004);
        ack_on(32'hB000_0000, 32'hDEAD_BEEF);
        chk("odd_wen1", 32'(bus.fifo_write_en1), 32'd1);
        chk("odd_wen2", 32'(bus.fifo_write_en2), 32'd0);
        chk("odd_d1", bus.fifo_write_data1, 32'hB000_0000);
        chk("odd_a1", bus.fifo_write_address1, 32'h8000_0004);
        chk("odd_d2", bus.fifo_write_data2, 32'd0);
        tick();
        ack_off();
        tick();
        chk("odd_next_addr", bus.icache_addr, 32'h8000_0008);
        ack_on(32'hB000_0001, 32'hB000_0002);
        chk("odd_next_wen2", 32'(bus.fifo_write_en2), 32'd1);
        tick();
        ack_off();

        // Full throttle in IDLE (pc now 0x80000010)
        bus.fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("full_req%0d", i), 32'(bus.icache_req), 32'd0);
        end
        bus.fifo_full = 1'b0;
        tick();
        chk("full_rel_req", 32'(bus.icache_req), 32'd1);
        chk("full_rel_addr", bus.icache_addr, 32'h8000_0010);
        ack_on(32'hC000_0000, 32'hC000_0001);
        tick();
        ack_off();

        // Redirect mid-request with delay slot
        redir(32'h0000_0100, 1'b0);
        tick();
        redir_off();
        tick();
        chk("mid_addr", bus.icache_addr, 32'h0000_0100);
        redir(32'h0000_0400, 1'b1);
        chk("mid_flush", 32'(bus.fifo_flush), 32'd1);
        chk("mid_flush_dly", 32'(bus.fifo_flush_with_delay), 32'd1);
        chk("mid_redir_wen1", 32'(bus.fifo_write_en1), 32'd0);
        tick();
        redir_off();
        chk("drop_req", 32'(bus.icache_req), 32'd1);
        chk("drop_addr", bus.icache_addr, 32'h0000_0100);
        ack_on(32'hD000_0000, 32'hD000_0001);
        chk("drop_ack_wen1", 32'(bus.fifo_write_en1), 32'd0);
        chk("drop_ack_wen2", 32'(bus.fifo_write_en2), 32'd0);
        tick();
        ack_off();
        chk("drop_idle_req", 32'(bus.icache_req), 32'd0);
        tick();
        chk("mid_next_req", 32'(bus.icache_req), 32'd1);
        chk("mid_next_addr", bus.icache_addr, 32'h0000_0400);

        // Redirect and ack in the same cycle
        ack_on(32'hE000_0000, 32'hE000_0001);
        redir(32'h0000_0800, 1'b0);
        chk("same_wen1", 32'(bus.fifo_write_en1), 32'd0);
        chk("same_flush", 32'(bus.fifo_flush), 32'd1);
        tick();
        redir_off();
        ack_off();
        chk("same_idle_req", 32'(bus.icache_req), 32'd0);
        tick();
        chk("same_next_addr", bus.icache_addr, 32'h0000_0800);

        // Reset taken while in DROP
        redir(32'h0000_0C00, 1'b0);
        tick();
        redir_off();
        chk("pre_rst_drop_req", 32'(bus.icache_req), 32'd1);
        rst = 1'b1;
        tick();
        ack_on(32'hF000_0000, 32'hF000_0001);
        chk("drop_rst_req", 32'(bus.icache_req), 32'd0);
        chk("drop_rst_addr", bus.icache_addr, 32'hBFC0_0000);
        chk("drop_rst_wen1", 32'(bus.fifo_write_en1), 32'd0);
        ack_off();
        rst = 1'b0;
        tick();
        chk("post_rst_req", 32'(bus.icache_req), 32'd1);
        chk("post_rst_addr", bus.icache_addr, 32'hBFC0_0000);
        ack_on(32'h1111_1111, 32'h2222_2222);
        tick();
        ack_off();

        // 32-bit PC wrap
        redir(32'hFFFF_FFF8, 1'b0);
        tick();
        redir_off();
        tick();
        chk("wrap_addr", bus.icache_addr, 32'hFFFF_FFF8);
        ack_on(32'h3333_3333, 32'h4444_4444);
        chk("wrap_a2", bus.fifo_write_address2, 32'hFFFF_FFFC);
        tick();
        ack_off();
        tick();
        chk("wrap_next_addr", bus.icache_addr, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
